// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC job arbiter and its round-robin picker.
package crc_pkg;

    localparam int CRC_BITS_PER_BYTE = 8;
    localparam int CRC_DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESULT  = 3'd5
    } crc_state_e;

endpackage

// File: rtl/crc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, cyclically.
module crc_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               found
);

    // Walk offsets from the far end down to zero so the nearest request to ptr wins last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                grant = ID_W'((int'(ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_job_arbiter.sv
// Per-job round-robin sequencer sharing one bit-serial CRC engine among byte-stream requesters.
// Optional feature: define CRC_TIMEOUT_EN to abort jobs whose requester stalls in FETCH.
module crc_job_arbiter
    import crc_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WIDTH       = CRC_DEFAULT_WIDTH,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 eng_initialize,
    output logic                 eng_shift,
    output logic [2:0]           eng_bit_index,
    output logic [7:0]           eng_data,
    input  logic [WIDTH-1:0]     eng_crc,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [WIDTH-1:0]     res_crc,
    output logic                 res_err
);

    localparam logic [2:0] LAST_BIT = 3'(CRC_BITS_PER_BYTE - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_params
        $error("crc_job_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC 1..255");
    end

    crc_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic             eng_initialize_q, eng_initialize_d;
    logic             eng_shift_q, eng_shift_d;
    logic [2:0]       eng_bit_index_q, eng_bit_index_d;
    logic [7:0]       eng_data_q, eng_data_d;
    logic             last_q, last_d;
    logic             res_valid_q, res_valid_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [WIDTH-1:0] res_crc_q, res_crc_d;
`ifdef CRC_TIMEOUT_EN
    logic             res_err_q, res_err_d;
    logic [7:0]       idle_q, idle_d;
`endif

    logic [ID_W-1:0]  pick_id;
    logic             pick_found;
    logic             handshake;
    logic [7:0]       sel_data;
    logic             sel_last;

    crc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_q),
        .grant (pick_id),
        .found (pick_found)
    );

    // Only the granted requester ever sees ready, and only while we wait for its byte.
    always_comb begin
        req_ready = '0;
        handshake = 1'b0;
        if (state_q == ST_FETCH) begin
            req_ready[grant_id_q] = req_valid[grant_id_q];
            handshake             = req_valid[grant_id_q];
        end
    end

    assign sel_data = req_data[8*int'(grant_id_q) +: 8];
    assign sel_last = req_last[grant_id_q];

    always_comb begin
        // NOTE: every _d starts from a hold/default value so no branch of the case infers a latch.
        state_d          = state_q;
        rr_d             = rr_q;
        grant_id_d       = grant_id_q;
        busy_d           = busy_q;
        eng_initialize_d = 1'b0;
        eng_shift_d      = eng_shift_q;
        eng_bit_index_d  = eng_bit_index_q;
        eng_data_d       = eng_data_q;
        last_d           = last_q;
        res_valid_d      = res_valid_q;
        res_id_d         = res_id_q;
        res_crc_d        = res_crc_q;
`ifdef CRC_TIMEOUT_EN
        res_err_d        = res_err_q;
        idle_d           = '0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d       = pick_id;
                    rr_d             = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + ID_W'(1);
                    busy_d           = 1'b1;
                    eng_initialize_d = 1'b1;
                    state_d          = ST_INIT;
`ifdef CRC_TIMEOUT_EN
                    res_err_d        = 1'b0;
`endif
                end
            end

            ST_INIT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (handshake) begin
                    eng_data_d      = sel_data;
                    last_d          = sel_last;
                    eng_shift_d     = 1'b1;
                    eng_bit_index_d = '0;
                    state_d         = ST_SHIFT;
                end
`ifdef CRC_TIMEOUT_EN
                else begin
                    idle_d = idle_q + 8'd1;
                    // A stalled requester forfeits the engine with an error result.
                    if (idle_d == 8'(TIMEOUT_CYC)) begin
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_crc_d   = '0;
                        res_id_d    = grant_id_q;
                        state_d     = ST_RESULT;
                    end
                end
`endif
            end

            ST_SHIFT: begin
                if (eng_bit_index_q == LAST_BIT) begin
                    eng_shift_d     = 1'b0;
                    eng_bit_index_d = '0;
                    state_d         = last_q ? ST_CAPTURE : ST_FETCH;
                end else begin
                    eng_bit_index_d = eng_bit_index_q + 3'd1;
                end
            end

            // The engine register has taken the final bit by now; sample it.
            ST_CAPTURE: begin
                res_crc_d   = eng_crc;
                res_id_d    = grant_id_q;
                res_valid_d = 1'b1;
                state_d     = ST_RESULT;
            end

            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            rr_q             <= '0;
            grant_id_q       <= '0;
            busy_q           <= 1'b0;
            eng_initialize_q <= 1'b0;
            eng_shift_q      <= 1'b0;
            eng_bit_index_q  <= '0;
            eng_data_q       <= '0;
            last_q           <= 1'b0;
            res_valid_q      <= 1'b0;
            res_id_q         <= '0;
            res_crc_q        <= '0;
`ifdef CRC_TIMEOUT_EN
            res_err_q        <= 1'b0;
            idle_q           <= '0;
`endif
        end else begin
            // NOTE: registers take non-blocking assignments; the next-state block above is blocking.
            state_q          <= state_d;
            rr_q             <= rr_d;
            grant_id_q       <= grant_id_d;
            busy_q           <= busy_d;
            eng_initialize_q <= eng_initialize_d;
            eng_shift_q      <= eng_shift_d;
            eng_bit_index_q  <= eng_bit_index_d;
            eng_data_q       <= eng_data_d;
            last_q           <= last_d;
            res_valid_q      <= res_valid_d;
            res_id_q         <= res_id_d;
            res_crc_q        <= res_crc_d;
`ifdef CRC_TIMEOUT_EN
            res_err_q        <= res_err_d;
            idle_q           <= idle_d;
`endif
        end
    end

    assign grant_id       = grant_id_q;
    assign busy           = busy_q;
    assign eng_initialize = eng_initialize_q;
    assign eng_shift      = eng_shift_q;
    assign eng_bit_index  = eng_bit_index_q;
    assign eng_data       = eng_data_q;
    assign res_valid      = res_valid_q;
    assign res_id         = res_id_q;
    assign res_crc        = res_crc_q;
`ifdef CRC_TIMEOUT_EN
    assign res_err        = res_err_q;
`else
    assign res_err        = 1'b0;
`endif

endmodule

// File: tb/tb_crc_job_arbiter.sv
// Directed bench for crc_job_arbiter with a reflected CRC-32 bit-serial engine model.
module tb_crc_job_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int WIDTH       = 32;
    localparam int ID_W        = 1;
    localparam int TIMEOUT_CYC = 10;
    localparam int CLK_PERIOD  = 10;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 eng_initialize;
    logic                 eng_shift;
    logic [2:0]           eng_bit_index;
    logic [7:0]           eng_data;
    logic [WIDTH-1:0]     eng_crc;
    logic                 res_valid;
    logic                 res_ready;
    logic [ID_W-1:0]      res_id;
    logic [WIDTH-1:0]     res_crc;
    logic                 res_err;

    int checks = 0;
    int errors = 0;

    crc_job_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .WIDTH       (WIDTH),
        .ID_W        (ID_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .grant_id       (grant_id),
        .busy           (busy),
        .eng_initialize (eng_initialize),
        .eng_shift      (eng_shift),
        .eng_bit_index  (eng_bit_index),
        .eng_data       (eng_data),
        .eng_crc        (eng_crc),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_id         (res_id),
        .res_crc        (res_crc),
        .res_err        (res_err)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD/2) clk = ~clk;

    // Reflected CRC-32 engine: LSB-first, poly 0xEDB88320, init/xor all ones.
    logic [31:0] crc_reg;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              crc_reg <= 32'hFFFF_FFFF;
        else if (eng_initialize) crc_reg <= 32'hFFFF_FFFF;
        else if (eng_shift)
            crc_reg <= (crc_reg >> 1) ^ ((crc_reg[0] ^ eng_data[eng_bit_index]) ? 32'hEDB8_8320 : 32'h0);
    end
    assign eng_crc = ~crc_reg;

    int both_ready = 0;
    int stray_ready = 0;
    always @(negedge clk) begin
        if (req_ready == 2'b11) both_ready++;
        if ((req_ready & ~(2'b01 << grant_id)) != 2'b00) stray_ready++;
    end

    typedef logic [7:0] bq_t [$];
    typedef struct {
        int          id;
        logic [7:0]  data;
        logic [31:0] crc;
        int          cycles;
    } vec_t;

    vec_t        vecs [4];
    bq_t         msg;
    int          cyc;
    int          gap_shift = 0;
    int          hold_bad;
    int          init_seen;
    logic [31:0] hold_crc;
    logic        hold_id;
    time         t_hs;
    time         t_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 2000) begin
            tick;
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_result(output time t);
        int n = 0;
        do begin
            tick;
            n++;
        end while (!res_valid && n < 2000);
        if (!res_valid) check("result_timeout", 32'(res_valid), 32'd1);
        t = $time;
    endtask

    task automatic send_byte(input int id, input logic [7:0] d, input logic l);
        int n = 0;
        req_valid[id]        = 1'b1;
        req_data[8*id +: 8]  = d;
        req_last[id]         = l;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 2000);
        if (!req_ready[id]) check("ready_timeout", 32'(req_ready), 32'(1 << id));
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    // Cycles are counted from the first cycle the job's valid is visible to an idle arbiter.
    task automatic run_job(input int id, input bq_t m, input int gap, output int cycles);
        time t0;
        time t1;
        wait_idle;
        t0 = $time;
        for (int i = 0; i < m.size(); i++) begin
            send_byte(id, m[i], i == m.size() - 1);
            if (gap > 0 && i < m.size() - 1) begin
                repeat (8) tick;
                repeat (gap) begin
                    if (eng_shift) gap_shift++;
                    tick;
                end
            end
        end
        wait_result(t1);
        cycles = int'((t1 - t0) / CLK_PERIOD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'h00, 32'hD202_EF8D, 12};
        vecs[1] = '{1, 8'h31, 32'h83DC_EFB7, 12};
        vecs[2] = '{0, 8'hFF, 32'hFF00_0000, 12};
        vecs[3] = '{1, 8'h61, 32'hE8B7_BE43, 12};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        res_ready = 1'b1;
        #1;
        check("por_ctrl", 32'({req_ready, grant_id, busy, eng_initialize, eng_shift, eng_bit_index,
                              eng_data, res_valid, res_id, res_err}), 32'd0);
        check("por_crc", res_crc, 32'd0);
        #22 rst_n = 1'b1;
        tick;

        // Single-byte jobs from a table.
        foreach (vecs[v]) begin
            msg = {vecs[v].data};
            run_job(vecs[v].id, msg, 0, cyc);
            check($sformatf("vec%0d_crc", v), res_crc, vecs[v].crc);
            check($sformatf("vec%0d_id", v), 32'(res_id), 32'(vecs[v].id));
            check($sformatf("vec%0d_err", v), 32'(res_err), 32'd0);
            check($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].cycles));
        end

        // "123456789" on requester 0, back-to-back bytes.
        msg.delete();
        for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
        run_job(0, msg, 0, cyc);
        check("check_crc", res_crc, 32'hCBF4_3926);
        check("check_id", 32'(res_id), 32'd0);
        check("check_cycles", 32'(cyc), 32'd84);

        // Same message on requester 1 with a 5-cycle valid gap before each later byte.
        run_job(1, msg, 5, cyc);
        check("gap_crc", res_crc, 32'hCBF4_3926);
        check("gap_id", 32'(res_id), 32'd1);
        check("gap_cycles", 32'(cyc), 32'd124);
        check("gap_no_shift", 32'(gap_shift), 32'd0);

        // Consumer stalls for 20 cycles while another requester waits.
        wait_idle;
        res_ready = 1'b0;
        msg = {8'h31};
        run_job(1, msg, 0, cyc);
        check("hold_first_crc", res_crc, 32'h83DC_EFB7);
        req_valid[0]      = 1'b1;
        req_data[7:0]     = 8'h00;
        req_last[0]       = 1'b1;
        hold_crc  = res_crc;
        hold_id   = res_id;
        hold_bad  = 0;
        init_seen = 0;
        repeat (20) begin
            tick;
            if (!res_valid || res_crc !== hold_crc || res_id !== hold_id) hold_bad++;
            if (eng_initialize) init_seen++;
        end
        check("hold_stable", 32'(hold_bad), 32'd0);
        check("hold_no_init", 32'(init_seen), 32'd0);
        check("hold_id", 32'(res_id), 32'd1);
        res_ready = 1'b1;
        tick;
        tick;
        check("init_after_release", 32'({eng_initialize, grant_id}), 32'b10);
        wait_result(t_res);
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        check("hold_next_crc", res_crc, 32'hD202_EF8D);
        check("hold_next_id", 32'(res_id), 32'd0);

        // Asynchronous reset in the middle of a SHIFT phase (requester 0 owns the engine, rr = 1).
        wait_idle;
        tick;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h31;
        req_last[0]   = 1'b0;
        cyc = 0;
        while (!eng_shift && cyc < 20) begin
            tick;
            cyc++;
        end
        check("rst_reached_shift", 32'(eng_shift), 32'd1);
        tick;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({req_ready, grant_id, busy, eng_initialize, eng_shift, eng_bit_index,
                                  eng_data, res_valid, res_id, res_err}), 32'd0);
        check("rst_mid_crc", res_crc, 32'd0);
        req_valid = '0;
        req_last  = '0;
        #10 rst_n = 1'b1;
        tick;
        tick;
        check("rst_idle", 32'({busy, res_valid, eng_initialize}), 32'd0);

        // Both requesters continuously offer a single 0x00 job: grants alternate from 0.
        req_valid = 2'b11;
        req_last  = 2'b11;
        req_data  = '0;
        for (int k = 0; k < 4; k++) begin
            wait_result(t_res);
            check($sformatf("rr%0d_id", k), 32'(res_id), 32'(k % 2));
            check($sformatf("rr%0d_grant", k), 32'(grant_id), 32'(k % 2));
            check($sformatf("rr%0d_crc", k), res_crc, 32'hD202_EF8D);
        end
        req_valid = '0;
        req_last  = '0;
        check("ready_never_both", 32'(both_ready), 32'd0);
        check("ready_only_granted", 32'(stray_ready), 32'd0);

`ifdef CRC_TIMEOUT_EN
        // Requester 0 stalls after its first (non-last) byte.
        wait_idle;
        send_byte(0, 8'h31, 1'b0);
        t_hs = $time;
        wait_result(t_res);
        check("to_cycles", 32'((t_res - t_hs) / CLK_PERIOD), 32'd18);
        check("to_err", 32'(res_err), 32'd1);
        check("to_crc", res_crc, 32'd0);
        check("to_id", 32'(res_id), 32'd0);
        msg = {8'h00};
        run_job(1, msg, 0, cyc);
        check("to_next_err", 32'(res_err), 32'd0);
        check("to_next_crc", res_crc, 32'hD202_EF8D);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_job_arbiter.md
Name: crc_job_arbiter

Overview:
- Sequences a single shared crcN engine and shares it between NUM_REQ byte-stream requesters.
- Each requester submits a whole message as a job: a byte stream with valid/ready/last.
- The block arbitrates round-robin per job. It drives the engine's initialize/shift/bit_index/data inputs and returns the final CRC tagged with the requester ID.
- It sits between requester front-ends and crc_main. The per-requester CRC configuration (poly/init/xor/width/reflect) is muxed outside the block using grant_id.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 32, CRC result width; matches the crcN instance.
- ID_W, $clog2(NUM_REQ), width of requester ID fields.
- TIMEOUT_CYC, 255, idle cycles before job abort (used only with CRC_TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  byte valid per requester
- req_data  in  8*NUM_REQ  byte per requester; requester i at [8i+7:8i]
- req_last  in  NUM_REQ  byte is last of the message
- req_ready  out  NUM_REQ  byte accepted this cycle (one-hot or zero)
- grant_id  out  ID_W  requester owning the engine; drives the external config mux
- busy  out  1  a job is in progress
- eng_initialize  out  1  load the engine with init value
- eng_shift  out  1  engine shifts one bit this cycle
- eng_bit_index  out  3  bit index within the current byte
- eng_data  out  8  byte currently being shifted
- eng_crc  in  WIDTH  engine result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_id  out  ID_W  requester of the result
- res_crc  out  WIDTH  final CRC
- res_err  out  1  job aborted (CRC_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE; round-robin pointer rr = 0.
  - All outputs are 0: req_ready, grant_id, busy, eng_*, res_valid, res_id, res_crc, res_err.
- FSM states: IDLE, INIT, FETCH, SHIFT, CAPTURE, RESULT.
- IDLE:
  - If any req_valid is high, pick the first requester at or after rr (cyclic). Register its ID into grant_id and go to INIT.
  - rr becomes grant_id+1, wrapping modulo NUM_REQ.
  - If no req_valid is high, stay in IDLE.
- INIT:
  - eng_initialize = 1 for exactly one cycle; busy = 1; go to FETCH.
- FETCH:
  - req_ready[grant_id] = req_valid[grant_id], combinationally. No other req_ready bit is ever high.
  - On handshake, latch req_data into eng_data, latch req_last into last_q, and go to SHIFT with bit counter = 0.
  - Otherwise hold in FETCH.
- SHIFT:
  - eng_shift = 1 and eng_bit_index = counter for exactly 8 cycles, counter 0..7.
  - At counter == 7: go to CAPTURE if last_q, else back to FETCH.
  - Per-byte throughput is therefore 9 cycles: 1 FETCH + 8 SHIFT.
- CAPTURE:
  - One cycle that lets the engine register settle.
  - At the end of the cycle, register res_crc = eng_crc and res_id = grant_id. Go to RESULT.
- RESULT:
  - res_valid = 1; hold res_crc, res_id and res_err stable until res_ready.
  - On res_valid && res_ready: go to IDLE, busy = 0.
  - A new arbitration can happen in the cycle after the handshake (IDLE).
- Latency, single-byte job with valid already high:
  - IDLE→INIT at edge 1, then INIT, FETCH, 8 SHIFT cycles, CAPTURE.
  - res_valid first rises 12 cycles after the arbitration edge.
- Other rules:
  - eng_data is held stable throughout SHIFT and CAPTURE.
  - Requesters not granted see req_ready = 0 and must hold their data.
  - req_valid dropping mid-job leaves the block waiting in FETCH indefinitely (timeout aside).
  - grant_id is stable from INIT through RESULT.
  - A zero-length message is not supported: the last flag is carried on a data byte.
- Reset asserted mid-job: the job is lost with no result. The requester must resubmit.

Optional Feature:
- Macro: CRC_TIMEOUT_EN.
- Enabled:
  - An 8-bit idle counter runs in FETCH and clears on each handshake.
  - When the counter reaches TIMEOUT_CYC, go to RESULT with res_err = 1 and res_crc = 0. The owning requester is released.
  - A new job clears res_err.
- Disabled:
  - The counter logic is absent, res_err is tied to 0, and FETCH waits forever.

Decomposition:
- Shared package crc_pkg holds:
  - The FSM state enum (IDLE..RESULT, 3 bits).
  - CRC_BITS_PER_BYTE = 8.
  - Default WIDTH.
- One natural sub-module, crc_rr_arbiter: combinational round-robin pick from a request vector and a pointer, outputting the grant index and a found flag.
- The FSM and datapath stay in crc_job_arbiter. Engine and config mux are instantiated by the parent.

Test Plan:
- Reset mid-SHIFT (drop rst_n asynchronously) → all outputs are 0 immediately; after release, state is IDLE and rr = 0.
- Requester 0 sends "123456789" (0x31..0x39, last on 0x39); engine configured for reflected CRC-32 (poly 0x04C11DB7, init/xor 0xFFFFFFFF) → res_crc = 0xCBF43926, res_id = 0, 9×9 + 3 cycles from grant to res_valid.
- Both requesters hold a 1-byte job 0x00 continuously → grants alternate 0,1,0,1; req_ready is never high for both; each result is tagged with the matching res_id.
- res_ready held low for 20 cycles in RESULT → res_valid, res_crc and res_id stay stable; no new INIT pulse until the handshake.
- Requester 1 drops req_valid for 5 cycles between bytes → FETCH holds, eng_shift = 0 during the gap, final CRC is unchanged versus the gapless run.
- CRC_TIMEOUT_EN with TIMEOUT_CYC = 10, requester stalls after the first byte → res_valid with res_err = 1, res_crc = 0 after 10 idle cycles; the next job completes normally with res_err = 0.
